// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the FP32 divider requester.
// Flag indices address the 6-bit response flag vector {timeout,underflow,overflow,zero,NaN,error}.
package fpu_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        RESPOND
    } div_state_t;

    localparam int FLG_W   = 6;
    localparam int FLG_ERR = 0;
    localparam int FLG_NAN = 1;
    localparam int FLG_ZRO = 2;
    localparam int FLG_OVF = 3;
    localparam int FLG_UNF = 4;
    localparam int FLG_TMO = 5;

    localparam logic [31:0] QNAN_F32 = 32'h7FC0_0000;

    function automatic logic [FLG_W-1:0] pack_flags(
        input logic tmo, input logic unf, input logic ovf,
        input logic zro, input logic nan, input logic err
    );
        logic [FLG_W-1:0] f;
        f          = '0;
        f[FLG_TMO] = tmo;
        f[FLG_UNF] = unf;
        f[FLG_OVF] = ovf;
        f[FLG_ZRO] = zro;
        f[FLG_NAN] = nan;
        f[FLG_ERR] = err;
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 depth, with registered occupancy count.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: storage is only DEPTH entries, so it shares the async reset with the
    // pointers; larger queues would leave the array unreset to map onto RAM.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignments keep every pointer update based on the
    // pre-edge values, so simultaneous push and pop need no special ordering.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_div_requester.sv
// Initiator for the FP32 divider start/ready handshake: queues tagged operand pairs,
// issues one divide at a time, and returns in-order responses with a completion watchdog.
module fpu_div_requester
    import fpu_div_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_s,
    output logic [FLG_W-1:0] rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             div_start,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic [31:0]      div_s,
    input  logic             div_ready,
    input  logic             div_error,
    input  logic             div_nan,
    input  logic             div_zero,
    input  logic             div_overflow,
    input  logic             div_underflow,
    output logic             busy
);

    localparam int ENTRY_W = 64 + TAG_W;
    localparam int WDOG_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    div_state_t       r_state;
    logic [TAG_W-1:0] r_op_tag;
    logic [WDOG_W-1:0] r_wdog;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_entry;

    assign w_entry   = {cmd_tag, cmd_a, cmd_b};
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign busy      = !w_empty || (r_state != IDLE);

    // Start is gated by div_ready combinationally so it can never assert into a busy divider.
    assign div_start = (r_state == ISSUE) && div_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op_tag  <= '0;
            r_wdog    <= '0;
            div_a     <= '0;
            div_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_s     <= '0;
            rsp_flags <= '0;
            rsp_tag   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        {r_op_tag, div_a, div_b} <= w_head;
                        r_state                  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (div_ready) begin
                        r_wdog  <= '0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (r_wdog == WDOG_LAST) begin
                        rsp_s     <= QNAN_F32;
                        rsp_flags <= pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                        rsp_tag   <= r_op_tag;
                        rsp_valid <= 1'b1;
                        r_state   <= RESPOND;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (!div_ready) r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Normal writeback and early exception exit both end with div_ready rising.
                    if (div_ready) begin
                        rsp_s     <= div_s;
                        rsp_flags <= pack_flags(1'b0, div_underflow, div_overflow,
                                                div_zero, div_nan, div_error);
                        rsp_tag   <= r_op_tag;
                        rsp_valid <= 1'b1;
                        r_state   <= RESPOND;
                    end else if (r_wdog == WDOG_LAST) begin
                        rsp_s     <= QNAN_F32;
                        rsp_flags <= pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                        rsp_tag   <= r_op_tag;
                        rsp_valid <= 1'b1;
                        r_state   <= RESPOND;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_requester.sv
// Directed bench for fpu_div_requester with a behavioural start/ready divider model.
// Divider results come from a lookup of hand-computed quotients.
module tb_fpu_div_requester;
    import fpu_div_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_s;
    logic [5:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        div_start;
    logic [31:0] div_a, div_b;
    logic [31:0] div_s;
    logic        div_ready;
    logic        div_error, div_nan, div_zero, div_overflow, div_underflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_bad_starts = 0;
    int m_busy = 4;
    bit m_hang = 1'b0;
    int m_cnt;

    always #5 clk_i = ~clk_i;

    fpu_div_requester dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_s        (rsp_s),
        .rsp_flags    (rsp_flags),
        .rsp_tag      (rsp_tag),
        .div_start    (div_start),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_s        (div_s),
        .div_ready    (div_ready),
        .div_error    (div_error),
        .div_nan      (div_nan),
        .div_zero     (div_zero),
        .div_overflow (div_overflow),
        .div_underflow(div_underflow),
        .busy         (busy)
    );

    // Returns {underflow, overflow, zero, nan, error, quotient}.
    function automatic logic [36:0] div_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h4040_0000, 32'h3F80_0000}: return {5'b00000, 32'h4040_0000};
            {32'h40C0_0000, 32'h4000_0000}: return {5'b00000, 32'h4040_0000};
            {32'h4100_0000, 32'h4080_0000}: return {5'b00000, 32'h4000_0000};
            {32'h7F00_0000, 32'h3E80_0000}: return {5'b01000, 32'h7F80_0000};
            {32'h0000_0000, 32'h3F80_0000}: return {5'b00100, 32'h0000_0000};
            {32'h7FC0_0000, 32'h3F80_0000}: return {5'b00010, 32'h7FC0_0000};
            {32'h0080_0000, 32'h7F00_0000}: return {5'b10000, 32'h0000_0000};
            default:                        return {5'b00001, 32'h7FC0_0000};
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            div_ready <= 1'b1;
            m_cnt     <= 0;
            div_s     <= '0;
            {div_underflow, div_overflow, div_zero, div_nan, div_error} <= '0;
        end else if (div_ready) begin
            if (div_start) begin
                div_ready <= 1'b0;
                m_cnt     <= m_busy - 1;
                {div_underflow, div_overflow, div_zero, div_nan, div_error, div_s} <= div_ref(div_a, div_b);
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else if (!m_hang) begin
            div_ready <= 1'b1;
        end
    end

    always @(posedge clk_i) begin
        if (div_start) n_starts <= n_starts + 1;
        if (div_start && !div_ready) n_bad_starts <= n_bad_starts + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && n < 300) begin tick(); n++; end
        check("send_ready", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input logic [31:0] s, input logic [5:0] fl, input logic [3:0] tag);
        int n = 0;
        while (!rsp_valid && n < 300) begin tick(); n++; end
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_s", 64'(rsp_s), 64'(s));
        check("rsp_flags", 64'(rsp_flags), 64'(fl));
        check("rsp_tag", 64'(rsp_tag), 64'(tag));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", 64'(rsp_valid), 64'(0));
    endtask

    task automatic latency_from_accept(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 300) begin tick(); lat++; end
    endtask

    initial begin
        int lat;
        int s0;
        int n;

        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_div_start", 64'(div_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        tick(); tick();

        // 1: single command, 20-cycle divide, latency 3 + 20
        m_busy = 20;
        s0 = n_starts;
        send(32'h4040_0000, 32'h3F80_0000, 4'd5);
        latency_from_accept(lat);
        check("t1_latency", 64'(lat), 64'(23));
        expect_rsp(32'h4040_0000, 6'b000000, 4'd5);
        check("t1_one_start", 64'(n_starts - s0), 64'(1));

        // 2: fill the FIFO behind a running divide, check backpressure and ordering
        m_busy = 8;
        s0 = n_starts;
        send(32'h40C0_0000, 32'h4000_0000, 4'd0);
        send(32'h4100_0000, 32'h4080_0000, 4'd1);
        send(32'h7F00_0000, 32'h3E80_0000, 4'd2);
        send(32'h0000_0000, 32'h3F80_0000, 4'd3);
        send(32'h7FC0_0000, 32'h3F80_0000, 4'd4);
        check("t2_full", 64'(cmd_ready), 64'(0));
        cmd_a = 32'h4040_0000; cmd_b = 32'h3F80_0000; cmd_tag = 4'd6; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_held_full", 64'(cmd_ready), 64'(0));
        end
        cmd_valid = 1'b0;
        expect_rsp(32'h4040_0000, 6'b000000, 4'd0);
        expect_rsp(32'h4000_0000, 6'b000000, 4'd1);
        expect_rsp(32'h7F80_0000, 6'b001000, 4'd2);
        expect_rsp(32'h0000_0000, 6'b000100, 4'd3);
        expect_rsp(32'h7FC0_0000, 6'b000010, 4'd4);
        check("t2_starts", 64'(n_starts - s0), 64'(5));
        check("t2_no_bad_start", 64'(n_bad_starts), 64'(0));

        // 3: divide by zero, divider exits early with error
        m_busy = 1;
        send(32'h3F80_0000, 32'h0000_0000, 4'd11);
        expect_rsp(32'h7FC0_0000, 6'b000001, 4'd11);
        tick();
        check("t3_idle", 64'(busy), 64'(0));

        // 4: divider never returns -> watchdog abort, then next command waits in ISSUE
        m_hang = 1'b1;
        send(32'h4040_0000, 32'h3F80_0000, 4'd9);
        latency_from_accept(lat);
        check("t4_abort_latency", 64'(lat), 64'(65));
        expect_rsp(32'h7FC0_0000, 6'b100001, 4'd9);
        m_busy = 3;
        s0 = n_starts;
        send(32'h40C0_0000, 32'h4000_0000, 4'd10);
        repeat (10) tick();
        check("t4_no_start", 64'(n_starts - s0), 64'(0));
        check("t4_busy", 64'(busy), 64'(1));
        check("t4_no_rsp", 64'(rsp_valid), 64'(0));
        m_hang = 1'b0;
        expect_rsp(32'h4040_0000, 6'b000000, 4'd10);
        check("t4_resumed_start", 64'(n_starts - s0), 64'(1));

        // 5: response backpressure holds outputs and blocks the next issue
        m_busy = 3;
        send(32'h4100_0000, 32'h4080_0000, 4'd7);
        send(32'h40C0_0000, 32'h4000_0000, 4'd8);
        n = 0;
        while (!rsp_valid && n < 300) begin tick(); n++; end
        s0 = n_starts;
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", 64'(rsp_valid), 64'(1));
            check("t5_hold_s", 64'(rsp_s), 64'(32'h4000_0000));
            check("t5_hold_flags_tag", 64'({rsp_flags, rsp_tag}), 64'({6'b000000, 4'd7}));
            tick();
        end
        check("t5_no_start", 64'(n_starts - s0), 64'(0));
        expect_rsp(32'h4000_0000, 6'b000000, 4'd7);
        expect_rsp(32'h4040_0000, 6'b000000, 4'd8);

        // 6: async reset during WAIT_DONE, then a clean command
        m_busy = 30;
        s0 = n_starts;
        send(32'h4040_0000, 32'h3F80_0000, 4'd3);
        n = 0;
        while (n_starts == s0 && n < 100) begin tick(); n++; end
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        check("t6_rsp_s", 64'(rsp_s), 64'(0));
        check("t6_rsp_flags_tag", 64'({rsp_flags, rsp_tag}), 64'(0));
        check("t6_div_ab", 64'({div_a, div_b}), 64'(0));
        check("t6_div_start", 64'(div_start), 64'(0));
        check("t6_cmd_ready", 64'(cmd_ready), 64'(1));
        check("t6_busy", 64'(busy), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        m_busy = 4;
        send(32'h0080_0000, 32'h7F00_0000, 4'd12);
        expect_rsp(32'h0000_0000, 6'b010000, 4'd12);
        check("final_no_bad_start", 64'(n_bad_starts), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
